// File: rtl/cell_request_arbiter_pkg.sv
// Shared types for the tic-tac-toe cell request path: cell index/one-hot types,
// arbiter states and requester source codes.
package tictactoe_pkg;
  localparam int NUM_CELLS = 9;

  typedef logic [3:0]           cell_idx_t;
  typedef logic [NUM_CELLS-1:0] cell_oh_t;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  localparam logic SRC_MOUSE = 1'b0;
  localparam logic SRC_KEY   = 1'b1;
endpackage

// File: rtl/cell_request_arbiter_if.sv
// Request/grant bundle between the two requesters, the board state and the arbiter.
interface cell_request_arbiter_if;
  logic                   mouse_valid;
  tictactoe_pkg::cell_idx_t mouse_cell;
  logic                   key_valid;
  tictactoe_pkg::cell_idx_t key_cell;
  logic                   block;
  tictactoe_pkg::cell_oh_t  x;
  tictactoe_pkg::cell_oh_t  o;
  tictactoe_pkg::cell_oh_t  cuadro;
  logic                   ack_mouse;
  logic                   ack_key;
  logic                   rej_mouse;
  logic                   rej_key;
  logic                   busy;
  logic                   grant_src;

  modport master (
    output mouse_valid, mouse_cell, key_valid, key_cell, block, x, o,
    input  cuadro, ack_mouse, ack_key, rej_mouse, rej_key, busy, grant_src
  );

  modport slave (
    input  mouse_valid, mouse_cell, key_valid, key_cell, block, x, o,
    output cuadro, ack_mouse, ack_key, rej_mouse, rej_key, busy, grant_src
  );
endinterface

// File: rtl/cell_index_decoder.sv
// 4-bit cell index to 9-bit one-hot; indices past the board decode to zero.
module cell_index_decoder
  import tictactoe_pkg::*;
(
  input  cell_idx_t idx_i,
  output cell_oh_t  onehot_o,
  output logic      in_range_o
);
  assign in_range_o = (idx_i < cell_idx_t'(NUM_CELLS));
  assign onehot_o   = in_range_o ? (cell_oh_t'(1) << idx_i) : '0;
endmodule

// File: rtl/cell_request_arbiter.sv
// Round-robin arbiter sharing the game FSM's one-hot cuadro input between mouse and keypad.
// Optional CELL_OCCUPIED_FILTER_EN rejects requests to cells already taken on x|o.
module cell_request_arbiter
  import tictactoe_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input logic                   clk_100MHz,
  input logic                   rst_n,
  cell_request_arbiter_if.slave bus
);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t GAP_LAST  = cnt_t'(GAP_CYCLES - 1);

  // Per-source vectors indexed by SRC_MOUSE / SRC_KEY.
  logic     [1:0]            valid, elig, good, in_range;
  cell_idx_t [1:0]           cell_idx;
  logic     [1:0][NUM_CELLS-1:0] oh;
  logic     [1:0]            armed_q, armed_d, ack_q, ack_d, rej_q, rej_d;

  arb_state_t state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cell_oh_t   cell_q, cell_d;
  logic       src_q, src_d, last_q, last_d;
  logic       win, lose;

  assign valid    = {bus.key_valid, bus.mouse_valid};
  assign cell_idx = {bus.key_cell, bus.mouse_cell};
  assign elig     = valid & armed_q & {2{~bus.block}};

`ifdef CELL_OCCUPIED_FILTER_EN
  cell_oh_t occ;
  assign occ = bus.x | bus.o;
`else
  logic unused_xo;
  assign unused_xo = ^{bus.x, bus.o};
`endif

  for (genvar s = 0; s < 2; s++) begin : g_src
    cell_index_decoder u_dec (
      .idx_i      (cell_idx[s]),
      .onehot_o   (oh[s]),
      .in_range_o (in_range[s])
    );
`ifdef CELL_OCCUPIED_FILTER_EN
    assign good[s] = in_range[s] & ~|(oh[s] & occ);
`else
    assign good[s] = in_range[s];
`endif
  end

  // On a tie the source that did not win last time goes first.
  assign win  = (elig == 2'b11) ? ~last_q : elig[SRC_KEY];
  assign lose = ~win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    src_d   = src_q;
    last_d  = last_q;
    ack_d   = '0;
    rej_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          if (good[win]) begin
            state_d    = GRANT;
            cnt_d      = '0;
            cell_d     = oh[win];
            src_d      = win;
            last_d     = win;
            ack_d[win] = 1'b1;
          end else begin
            // A good loser waits for the next IDLE cycle; a bad one is dropped now too.
            rej_d[win] = 1'b1;
            if (elig[lose] && !good[lose]) rej_d[lose] = 1'b1;
          end
        end
      end
      GRANT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A held level must be seen low before it can request again.
    armed_d = (armed_q | ~valid) & ~ack_d & ~rej_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cell_q  <= '0;
      src_q   <= SRC_MOUSE;
      last_q  <= SRC_KEY;
      armed_q <= '0;
      ack_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
      src_q   <= src_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
    end
  end

  assign bus.cuadro    = (state_q == GRANT) ? cell_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_src = src_q;
  assign bus.ack_mouse = ack_q[SRC_MOUSE];
  assign bus.ack_key   = ack_q[SRC_KEY];
  assign bus.rej_mouse = rej_q[SRC_MOUSE];
  assign bus.rej_key   = rej_q[SRC_KEY];
endmodule

// File: tb/tb_cell_request_arbiter.sv
// Directed bench for cell_request_arbiter with a cycle-level timeline model and
// per-cycle output comparison; follows CELL_OCCUPIED_FILTER_EN if defined.
module tb_cell_request_arbiter;
  localparam int H = 4;
  localparam int G = 2;
`ifdef CELL_OCCUPIED_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  logic rst_n      = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  cell_request_arbiter_if bif ();

  cell_request_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the last grant edge; the board sees the
  // cell for the first H cycles, busy lasts H+G cycles, then idle.
  int       m_t = H + G;
  bit [1:0] m_armed = '0;
  bit       m_last = 1'b1;
  bit       m_src = 1'b0;
  bit [8:0] m_cell = '0;
  bit [1:0] m_ack = '0, m_rej = '0;
  bit [1:0] mv, mel;
  int       mc [2];
  int       first, second;

  function automatic bit cell_ok(input int c, input bit [8:0] occ);
    if (c > 8) return 1'b0;
    if (FILT && occ[c]) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk_100MHz);
    if (!rst_n) begin
      m_t = H + G; m_armed = '0; m_last = 1'b1; m_src = 1'b0; m_ack = '0; m_rej = '0;
    end else begin
      mv    = {bif.key_valid, bif.mouse_valid};
      mc[0] = int'(bif.mouse_cell);
      mc[1] = int'(bif.key_cell);
      mel   = mv & m_armed & {2{~bif.block}};
      m_ack = '0;
      m_rej = '0;
      if (m_t >= H + G) begin
        if (mel != 2'b00) begin
          if (mel == 2'b11) first = m_last ? 0 : 1;
          else              first = mel[1] ? 1 : 0;
          second = 1 - first;
          if (cell_ok(mc[first], bif.x | bif.o)) begin
            m_ack[first] = 1'b1;
            m_t = 0;
            m_cell = '0;
            m_cell[mc[first]] = 1'b1;
            m_src = first[0];
            m_last = first[0];
          end else begin
            m_rej[first] = 1'b1;
            if (mel[second] && !cell_ok(mc[second], bif.x | bif.o)) m_rej[second] = 1'b1;
          end
        end
      end else begin
        m_t++;
      end
      for (int s = 0; s < 2; s++) begin
        if (!mv[s]) m_armed[s] = 1'b1;
        if (m_ack[s] || m_rej[s]) m_armed[s] = 1'b0;
      end
    end
  end

  always @(negedge clk_100MHz) begin
    if (chk_en) begin
      chk("cuadro",    32'(bif.cuadro),    32'((m_t < H) ? m_cell : 9'h0));
      chk("busy",      32'(bif.busy),      32'(m_t < H + G));
      chk("grant_src", 32'(bif.grant_src), 32'(m_src));
      chk("ack_mouse", 32'(bif.ack_mouse), 32'(m_ack[0]));
      chk("ack_key",   32'(bif.ack_key),   32'(m_ack[1]));
      chk("rej_mouse", 32'(bif.rej_mouse), 32'(m_rej[0]));
      chk("rej_key",   32'(bif.rej_key),   32'(m_rej[1]));
    end
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic drop_and_wait();
    bif.mouse_valid = 1'b0;
    bif.key_valid   = 1'b0;
    repeat (8) tick();
  endtask

  int c_cnt, b_cnt, a_cnt, k;

  initial begin
    bif.mouse_valid = 1'b0; bif.mouse_cell = '0;
    bif.key_valid   = 1'b0; bif.key_cell   = '0;
    bif.block = 1'b0; bif.x = '0; bif.o = '0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_cuadro", 32'(bif.cuadro), 32'h0);
    chk("rst_busy",   32'(bif.busy),   32'h0);
    chk("rst_src",    32'(bif.grant_src), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: single mouse grant, hold/gap timing
    bif.mouse_cell = 4'd4; bif.mouse_valid = 1'b1;
    tick();
    chk("t1_ack", 32'(bif.ack_mouse), 32'h1);
    chk("t1_cuadro0", 32'(bif.cuadro), 32'h010);
    bif.mouse_valid = 1'b0;
    c_cnt = 0; b_cnt = 0; a_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bif.cuadro == 9'h010) c_cnt++;
      if (bif.busy) b_cnt++;
      if (bif.ack_mouse) a_cnt++;
      tick();
    end
    chk("t1_hold_cycles", 32'(c_cnt), 32'd4);
    chk("t1_busy_cycles", 32'(b_cnt), 32'd6);
    chk("t1_ack_pulses",  32'(a_cnt), 32'd1);

    // 2: simultaneous requests after reset, mouse first then key 7 cycles later
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bif.mouse_cell = 4'd0; bif.key_cell = 4'd8;
    bif.mouse_valid = 1'b1; bif.key_valid = 1'b1;
    tick();
    chk("t2_ack_mouse", 32'(bif.ack_mouse), 32'h1);
    chk("t2_cuadro_m",  32'(bif.cuadro), 32'h001);
    k = 0;
    do begin tick(); k++; end while (!bif.ack_key && k < 20);
    chk("t2_key_spacing", 32'(k), 32'd7);
    chk("t2_cuadro_k",    32'(bif.cuadro), 32'h100);
    chk("t2_src_k",       32'(bif.grant_src), 32'h1);
    drop_and_wait();

    // 3: out-of-range key cell, held level rejects once
    bif.key_cell = 4'd9; bif.key_valid = 1'b1;
    tick();
    chk("t3_rej", 32'(bif.rej_key), 32'h1);
    chk("t3_cuadro", 32'(bif.cuadro), 32'h0);
    a_cnt = 0;
    repeat (5) begin tick(); if (bif.rej_key) a_cnt++; end
    chk("t3_no_rerej", 32'(a_cnt), 32'd0);
    bif.key_valid = 1'b0; tick(); bif.key_valid = 1'b1; tick();
    chk("t3_rej_again", 32'(bif.rej_key), 32'h1);
    drop_and_wait();

    // 4: block holds off a pending request
    bif.block = 1'b1; bif.mouse_cell = 4'd3; bif.mouse_valid = 1'b1;
    a_cnt = 0;
    repeat (10) begin tick(); if (bif.ack_mouse) a_cnt++; end
    chk("t4_blocked", 32'(a_cnt), 32'd0);
    bif.block = 1'b0;
    tick();
    chk("t4_ack", 32'(bif.ack_mouse), 32'h1);
    chk("t4_cuadro", 32'(bif.cuadro), 32'h008);
    drop_and_wait();

    // 5: reset during second GRANT cycle
    bif.mouse_cell = 4'd5; bif.mouse_valid = 1'b1;
    tick();
    chk("t5_cuadro", 32'(bif.cuadro), 32'h020);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_cuadro", 32'(bif.cuadro), 32'h0);
    chk("t5_rst_busy",   32'(bif.busy), 32'h0);
    rst_n = 1'b1;
    a_cnt = 0;
    repeat (10) begin tick(); if (bif.ack_mouse) a_cnt++; end
    chk("t5_no_regrant", 32'(a_cnt), 32'd0);
    bif.mouse_valid = 1'b0; tick(); bif.mouse_valid = 1'b1; tick();
    chk("t5_regrant", 32'(bif.ack_mouse), 32'h1);
    drop_and_wait();

    // 6: occupied cell
    bif.x = 9'h004; bif.mouse_cell = 4'd2; bif.mouse_valid = 1'b1;
    tick();
    if (FILT) begin
      chk("t6_rej",    32'(bif.rej_mouse), 32'h1);
      chk("t6_cuadro", 32'(bif.cuadro), 32'h0);
    end else begin
      chk("t6_ack",    32'(bif.ack_mouse), 32'h1);
      chk("t6_cuadro", 32'(bif.cuadro), 32'h004);
    end
    drop_and_wait();
    bif.x = '0;

    // 7: round-robin winner (key) is bad, mouse served next cycle
    bif.mouse_cell = 4'd1; bif.key_cell = 4'd12;
    bif.mouse_valid = 1'b1; bif.key_valid = 1'b1;
    tick();
    chk("t7_rej_key", 32'(bif.rej_key), 32'h1);
    chk("t7_no_ack",  32'(bif.ack_mouse), 32'h0);
    tick();
    chk("t7_ack_mouse", 32'(bif.ack_mouse), 32'h1);
    chk("t7_cuadro",    32'(bif.cuadro), 32'h002);
    drop_and_wait();

    // 8: both bad in one cycle
    bif.mouse_cell = 4'd10; bif.key_cell = 4'd15;
    bif.mouse_valid = 1'b1; bif.key_valid = 1'b1;
    tick();
    chk("t8_rej_both", 32'({bif.rej_key, bif.rej_mouse}), 32'h3);
    drop_and_wait();

    // 9: tie after a mouse grant goes to the keypad
    bif.mouse_cell = 4'd6; bif.key_cell = 4'd7;
    bif.mouse_valid = 1'b1; bif.key_valid = 1'b1;
    tick();
    chk("t9_ack_key", 32'(bif.ack_key), 32'h1);
    chk("t9_cuadro",  32'(bif.cuadro), 32'h080);
    repeat (7) tick();
    chk("t9_ack_mouse", 32'(bif.ack_mouse), 32'h1);
    chk("t9_cuadro_m",  32'(bif.cuadro), 32'h040);
    drop_and_wait();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
